// File: rtl/baud_cfg_pkg.sv
// Shared definitions for the UART baud-rate configuration path.
package baud_cfg_pkg;

  // Rate select encodings, shared with BaudGen
  localparam logic [1:0] BAUD24  = 2'b00;
  localparam logic [1:0] BAUD48  = 2'b01;
  localparam logic [1:0] BAUD96  = 2'b10;
  localparam logic [1:0] BAUD192 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    APPLY  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/baud_cfg_ctrl_cycle_timer.sv
// Loadable down-counter; done flag asserts once the count reaches zero.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load wins over count; decrement saturates at zero instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Runtime baud-rate change controller: drains Tx/Rx, applies the new rate,
// holds BaudGen in reset for a settle window, then acknowledges.
module baud_cfg_ctrl
  import baud_cfg_pkg::*;
#(
  parameter logic [1:0] DEFAULT_RATE   = BAUD96,
  parameter int         SETTLE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_cfg_req,
  input  logic [1:0] i_cfg_rate,
  output logic       o_cfg_ack,
  output logic       o_cfg_err,
  output logic       o_ready,
  input  logic       i_tx_busy,
  input  logic       i_rx_busy,
  output logic       o_hold,
  output logic [1:0] o_baud_rate,
  output logic       o_baud_gen_reset_n
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  // Both timers count remaining edges after the one that loads them
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE_CYCLES - 1);

  cfg_state_e r_state;
  logic [1:0] r_pend_rate;
  logic [1:0] r_baud_rate;
  logic       r_hold;
  logic       r_ack;
  logic       r_err;
  logic       r_bgrn;
  logic       r_idle_seen;

  logic w_busy;
  logic w_go_apply;
  logic w_to_done;
  logic w_st_done;

  assign w_busy     = i_tx_busy | i_rx_busy;
  // Second consecutive idle sample in DRAIN
  assign w_go_apply = (r_state == DRAIN) && !w_busy && r_idle_seen;

  // DRAIN timeout: reloaded every IDLE cycle, counts DRAIN edges
  cycle_timer #(.W(TO_W)) u_to_timer (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_load     (r_state == IDLE),
    .i_load_val (TO_LOAD),
    .i_en       (r_state == DRAIN),
    .o_done     (w_to_done)
  );

  // Settle window: loaded when the new rate is applied, counts APPLY/SETTLE edges
  cycle_timer #(.W(ST_W)) u_st_timer (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_load     (w_go_apply),
    .i_load_val (ST_LOAD),
    .i_en       ((r_state == APPLY) || (r_state == SETTLE)),
    .o_done     (w_st_done)
  );

  // Control FSM with registered outputs; rate and BaudGen reset change on APPLY entry
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pend_rate <= DEFAULT_RATE;
      r_baud_rate <= DEFAULT_RATE;
      r_hold      <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_bgrn      <= 1'b0;
      r_idle_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bgrn      <= 1'b1;
          r_idle_seen <= 1'b0;
          if (i_cfg_req) begin
            if (i_cfg_rate == r_baud_rate) begin
              r_state <= DONE;
              r_ack   <= 1'b1;
              r_err   <= 1'b0;
            end else begin
              r_pend_rate <= i_cfg_rate;
              r_hold      <= 1'b1;
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          r_idle_seen <= !w_busy;
          if (w_go_apply) begin
            r_state     <= APPLY;
            r_baud_rate <= r_pend_rate;
            r_bgrn      <= 1'b0;
          end else if (w_to_done) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_hold  <= 1'b0;
          end
        end
        APPLY, SETTLE: begin
          if (w_st_done) begin
            r_state <= DONE;
            r_bgrn  <= 1'b1;
            r_hold  <= 1'b0;
            r_ack   <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_state <= SETTLE;
          end
        end
        DONE: begin
          if (!i_cfg_req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cfg_ack          = r_ack;
  assign o_cfg_err          = r_err;
  assign o_ready            = (r_state == IDLE);
  assign o_hold             = r_hold;
  assign o_baud_rate        = r_baud_rate;
  assign o_baud_gen_reset_n = r_bgrn;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Randomized bench for baud_cfg_ctrl with a transaction-level timeline model.
module tb_baud_cfg_ctrl;
  import baud_cfg_pkg::*;

  localparam int S = 4;
  localparam int T = 16;

  logic       gclk = 1'b0;
  logic       rst  = 1'b1;
  logic       req  = 1'b0;
  logic [1:0] rate = 2'b00;
  logic       txb  = 1'b0;
  logic       rxb  = 1'b0;
  logic       ack, err, rdy, hold, bgrn;
  logic [1:0] baud;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] cur    = BAUD96;

  always #5 gclk = ~gclk;

  baud_cfg_ctrl #(
    .DEFAULT_RATE   (BAUD96),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clock            (gclk),
    .i_reset            (rst),
    .i_cfg_req          (req),
    .i_cfg_rate         (rate),
    .o_cfg_ack          (ack),
    .o_cfg_err          (err),
    .o_ready            (rdy),
    .i_tx_busy          (txb),
    .i_rx_busy          (rxb),
    .o_hold             (hold),
    .o_baud_rate        (baud),
    .o_baud_gen_reset_n (bgrn)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int c, input logic e_ack, input logic e_err,
                         input logic e_rdy, input logic e_hold, input logic e_bgrn,
                         input logic [1:0] e_baud);
    chk($sformatf("%s.ack@%0d",  tag, c), {31'd0, ack},  {31'd0, e_ack});
    chk($sformatf("%s.err@%0d",  tag, c), {31'd0, err},  {31'd0, e_err});
    chk($sformatf("%s.rdy@%0d",  tag, c), {31'd0, rdy},  {31'd0, e_rdy});
    chk($sformatf("%s.hold@%0d", tag, c), {31'd0, hold}, {31'd0, e_hold});
    chk($sformatf("%s.bgrn@%0d", tag, c), {31'd0, bgrn}, {31'd0, e_bgrn});
    chk($sformatf("%s.baud@%0d", tag, c), {30'd0, baud}, {30'd0, e_baud});
  endtask

  // One request. mode: 0 idle, 1 random busy, 2 rx stuck, 3 tx run + rx pulse (random),
  // 4 tx busy to edge 10 + rx pulse at 12. abort_at>0 resets the DUT after that cycle.
  task automatic run_req(input string tag, input logic [1:0] r, input int mode, input int abort_at);
    bit         bt[0:47];
    bit         br[0:47];
    int         l1, l2, ja, last;
    bit         same, tmo;
    logic [1:0] old;
    l1 = (mode == 4) ? 10 : $urandom_range(1, 10);
    l2 = l1 + 2;
    for (int j = 0; j < 48; j++) begin
      case (mode)
        1:       begin bt[j] = ($urandom_range(0, 3) == 0); br[j] = ($urandom_range(0, 3) == 0); end
        2:       begin bt[j] = 1'b0; br[j] = 1'b1; end
        3, 4:    begin bt[j] = (j <= l1); br[j] = (j == l2); end
        default: begin bt[j] = 1'b0; br[j] = 1'b0; end
      endcase
    end
    old  = cur;
    same = (r == cur);
    // Index j = busy sampled at edge k+j; need two idle samples in a row within T edges
    ja = 0;
    if (!same)
      for (int j = 2; j <= T; j++)
        if (!(bt[j-1] | br[j-1]) && !(bt[j] | br[j])) begin ja = j; break; end
    tmo  = !same && (ja == 0);
    last = same ? 1 : (tmo ? T + 1 : ja + S + 1);

    req  = 1'b1;
    rate = r;
    txb  = 1'($urandom);
    rxb  = 1'($urandom);
    tick();  // edge k
    for (int c = 1; c <= last; c++) begin
      if (c == last)
        chk_out(tag, c, 1'b1, tmo, 1'b0, 1'b0, 1'b1, tmo ? old : r);
      else if (c <= ja || tmo)
        chk_out(tag, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, old);
      else
        chk_out(tag, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r);
      if (!same && c == abort_at && c < last) begin
        rst = 1'b1;
        req = 1'b0;
        tick();
        chk_out({tag, ".rst"}, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BAUD96);
        rst = 1'b0;
        tick();
        chk_out({tag, ".rel"}, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BAUD96);
        cur = BAUD96;
        return;
      end
      txb  = bt[c];
      rxb  = br[c];
      rate = 2'($urandom);  // changes after sampling are ignored
      if (c < last) tick();
    end
    if (!tmo) cur = r;
    // Four-phase: ack holds while req stays high
    for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
      tick();
      chk_out({tag, ".hold_req"}, n, 1'b1, tmo, 1'b0, 1'b0, 1'b1, cur);
    end
    req = 1'b0;
    tick();
    chk_out({tag, ".drop"}, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur);
    txb = 1'($urandom);
    rxb = 1'($urandom);
    tick();
    chk_out({tag, ".idle"}, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur);
  endtask

  initial begin
    logic [1:0] r;
    int         md, ab;
    // Reset held for 3 cycles, BaudGen released one cycle after
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BAUD96);
    end
    rst = 1'b0;
    tick();
    chk_out("reset_rel", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BAUD96);

    run_req("same",     BAUD96,  1, 0);
    run_req("rst_mid",  BAUD24,  0, 5);
    run_req("after_rst", BAUD24, 0, 0);
    run_req("chg_idle", BAUD192, 0, 0);
    run_req("drain",    cur ^ 2'b01, 4, 0);
    run_req("timeout",  cur ^ 2'b10, 2, 0);

    for (int i = 0; i < 30; i++) begin
      md = $urandom_range(0, 3);
      r  = ($urandom_range(0, 4) == 0) ? cur : (cur ^ 2'($urandom_range(1, 3)));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0;
      run_req($sformatf("rnd%0d", i), r, md, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
